ntm_reading_stage: RTL and testbench
====================================

Name: ntm_reading_stage

Overview:
- Read-vector stage directly downstream of the NTM read heads.
- Computes r(k) = sum over j of w(j)*M(j,k) for one read head, using the head's weighting w (length N) and the memory matrix M (N x W).
- w is loaded once into an internal buffer; M is then streamed column by column, and one r(k) word is emitted per column.
- Output feeds the controller input-concatenation stage.

Parameters:
DATA_SIZE, 64, word width; signed two's-complement fixed point
FRAC_SIZE, 32, fractional bits of the fixed-point format
N_MAX, 64, maximum memory rows (weighting length)
W_MAX, 64, maximum memory row width (read-vector length)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset, asynchronous, active-high
START  in  1  one-cycle request to begin; sampled only in IDLE
READY  out  1  one-cycle pulse when the run completes or is rejected
SIZE_ERROR  out  1  set on a rejected START; cleared by the next accepted START
SIZE_N_IN  in  $clog2(N_MAX)+1  rows N; sampled on START
SIZE_W_IN  in  $clog2(W_MAX)+1  columns W; sampled on START
W_IN_VALID  in  1  weighting beat valid
W_IN_READY  out  1  weighting beat accepted when VALID && READY
W_IN  in  DATA_SIZE  w(j), j ascending
M_IN_VALID  in  1  memory beat valid
M_IN_READY  out  1  memory beat accepted when VALID && READY
M_IN  in  DATA_SIZE  M(j,k); k outer, j inner (column-major)
R_OUT_VALID  out  1  read-vector word valid
R_OUT_READY  in  1  downstream accepts when VALID && READY
R_OUT  out  DATA_SIZE  r(k), k ascending
R_OUT_LAST  out  1  high with r(W-1)

Behaviour:
- Reset: all outputs 0; state IDLE; j, k and accumulator cleared. Reset mid-run aborts the run immediately; no READY pulse is generated.
- IDLE:
  - START with 1<=N<=N_MAX and 1<=W<=W_MAX: latch N and W, clear SIZE_ERROR, go to LOAD_W.
  - START with an out-of-range size (including 0): set SIZE_ERROR, pulse READY on the next cycle, stay IDLE, emit nothing.
  - START in any state other than IDLE is ignored.
- LOAD_W:
  - W_IN_READY=1.
  - Each accepted beat writes buf[j] and increments j.
  - After beat N-1: j=0, k=0, acc=0, go to STREAM_M.
- STREAM_M:
  - M_IN_READY=1.
  - Each accepted beat: acc <= acc + ((buf[j]*M_IN) >>> FRAC_SIZE), truncated to DATA_SIZE.
    - Product is formed at full 2*DATA_SIZE width; the shift is arithmetic.
    - The add wraps modulo 2^DATA_SIZE; no saturation.
  - The beat with j=N-1 moves acc+term into the R_OUT register, asserts R_OUT_VALID, and goes to EMIT (one-cycle latency from last beat to valid).
- EMIT:
  - M_IN_READY=0; R_OUT and R_OUT_LAST are held stable while R_OUT_READY=0.
  - On accept: drop R_OUT_VALID, clear acc, j=0.
    - If k=W-1: go to DONE.
    - Otherwise: k++ and return to STREAM_M.
- DONE: pulse READY for one cycle, go to IDLE.
- W_IN_READY and M_IN_READY are never 1 outside LOAD_W and STREAM_M respectively; beats presented at other times are not consumed.
- N=1: every M beat completes a column. W=1: a single R_OUT with R_OUT_LAST=1.
- Peak throughput: one M beat per cycle, plus one bubble per column for EMIT.

Test Plan:
- N=2, W=3, Q32 (1.0=2^32): w={1.0,0.5}; M beats {2,2},{4,2},{6,2} (in 1.0 units) -> R_OUT = 3.0, 5.0, 7.0; R_OUT_LAST on 7.0; READY pulse one cycle after the last accept.
- Same run with R_OUT_READY held low 5 cycles on r(1) -> R_OUT stays 5.0 and M_IN_READY=0 throughout; remaining output is unchanged.
- N=1, W=1: w=-1.0, M=0.5 -> R_OUT=0xFFFFFFFF80000000 (-0.5), R_OUT_LAST=1.
- SIZE_N_IN=0 (also N_MAX+1) -> SIZE_ERROR=1, READY pulse next cycle, no W_IN_READY and no R_OUT_VALID; a following valid START clears SIZE_ERROR.
- RST asserted after 3 M beats -> all outputs 0 at once; a fresh START with the first test's data yields 3.0/5.0/7.0.
- START pulsed during STREAM_M -> ignored; outputs match the first test exactly.

Source files
------------

// File: rtl/ntm_reading_stage.sv
// ntm_reading_stage: read-vector stage for one NTM read head.
// Computes r(k) = sum_j w(j)*M(j,k) in signed fixed point (FRAC_SIZE fractional bits).
// The weighting w is loaded once into a local buffer. M is then streamed column-major,
// and one r(k) word is emitted per column.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for START; sizes are checked here
// LOAD_W   | accepting N weighting beats into the buffer
// STREAM_M | accepting M beats of column k and accumulating
// EMIT     | holding r(k) on R_OUT until downstream accepts
// DONE     | one-cycle READY pulse, then back to IDLE
//
// Ports:
//   CLK, RST                           clock, async active-high reset
//   START, SIZE_N_IN, SIZE_W_IN        run request and sizes (sampled in IDLE)
//   READY, SIZE_ERROR                  completion/reject pulse, size error flag
//   W_IN_VALID/W_IN_READY/W_IN         weighting stream, j ascending
//   M_IN_VALID/M_IN_READY/M_IN         memory stream, column-major
//   R_OUT_VALID/R_OUT_READY/R_OUT/R_OUT_LAST  read-vector output stream
module ntm_reading_stage #(
  parameter int DATA_SIZE = 64,
  parameter int FRAC_SIZE = 32,
  parameter int N_MAX     = 64,
  parameter int W_MAX     = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  output logic                       READY,
  output logic                       SIZE_ERROR,
  input  logic [$clog2(N_MAX):0]     SIZE_N_IN,
  input  logic [$clog2(W_MAX):0]     SIZE_W_IN,
  input  logic                       W_IN_VALID,
  output logic                       W_IN_READY,
  input  logic [DATA_SIZE-1:0]       W_IN,
  input  logic                       M_IN_VALID,
  output logic                       M_IN_READY,
  input  logic [DATA_SIZE-1:0]       M_IN,
  output logic                       R_OUT_VALID,
  input  logic                       R_OUT_READY,
  output logic [DATA_SIZE-1:0]       R_OUT,
  output logic                       R_OUT_LAST
);

  localparam int NW = $clog2(N_MAX) + 1;
  localparam int WW = $clog2(W_MAX) + 1;
  localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [NW-1:0] N_MAX_L = NW'(N_MAX);
  localparam logic [WW-1:0] W_MAX_L = WW'(W_MAX);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM_M, EMIT, DONE} state_t;

  state_t r_state, w_next;

  logic [NW-1:0]        r_n, r_j;
  logic [WW-1:0]        r_w, r_k;
  logic [DATA_SIZE-1:0] r_acc, r_rout;
  logic                 r_size_err, r_reject;
  logic [DATA_SIZE-1:0] r_buf [N_MAX];

  logic                     w_size_ok, w_w_fire, w_m_fire, w_r_fire;
  logic                     w_j_last, w_k_last;
  logic [DATA_SIZE-1:0]     w_buf_rd, w_term, w_acc_next;
  logic [2*DATA_SIZE-1:0]   w_prod;
  logic signed [2*DATA_SIZE-1:0] w_shift;

  assign w_size_ok = (SIZE_N_IN != '0) && (SIZE_N_IN <= N_MAX_L) &&
                     (SIZE_W_IN != '0) && (SIZE_W_IN <= W_MAX_L);

  assign w_w_fire = (r_state == LOAD_W)   && W_IN_VALID;
  assign w_m_fire = (r_state == STREAM_M) && M_IN_VALID;
  assign w_r_fire = (r_state == EMIT)     && R_OUT_READY;
  assign w_j_last = (r_j == r_n - NW'(1));
  assign w_k_last = (r_k == r_w - WW'(1));

  // Full-width signed product: sign-extend both operands so the unsigned
  // 2*DATA_SIZE multiply yields the two's-complement result.
  assign w_buf_rd   = r_buf[r_j[IW-1:0]];
  assign w_prod     = {{DATA_SIZE{w_buf_rd[DATA_SIZE-1]}}, w_buf_rd} *
                      {{DATA_SIZE{M_IN[DATA_SIZE-1]}}, M_IN};
  assign w_shift    = $signed(w_prod) >>> FRAC_SIZE;
  assign w_term     = w_shift[DATA_SIZE-1:0];
  assign w_acc_next = r_acc + w_term;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (START && w_size_ok) w_next = LOAD_W;
      LOAD_W:   if (w_w_fire && w_j_last) w_next = STREAM_M;
      STREAM_M: if (w_m_fire && w_j_last) w_next = EMIT;
      EMIT:     if (w_r_fire) w_next = w_k_last ? DONE : STREAM_M;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    READY       = (r_state == DONE) || r_reject;
    W_IN_READY  = (r_state == LOAD_W);
    M_IN_READY  = (r_state == STREAM_M);
    R_OUT_VALID = (r_state == EMIT);
    R_OUT_LAST  = (r_state == EMIT) && w_k_last;
  end

  assign R_OUT      = r_rout;
  assign SIZE_ERROR = r_size_err;

  // Datapath: sizes, indices, accumulator and output word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_n        <= '0;
      r_w        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_rout     <= '0;
      r_size_err <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        IDLE: if (START) begin
          if (w_size_ok) begin
            r_n        <= SIZE_N_IN;
            r_w        <= SIZE_W_IN;
            r_size_err <= 1'b0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
          end else begin
            r_size_err <= 1'b1;
            r_reject   <= 1'b1;
          end
        end
        LOAD_W: if (w_w_fire) begin
          if (w_j_last) begin
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
          end else begin
            r_j <= r_j + NW'(1);
          end
        end
        STREAM_M: if (w_m_fire) begin
          r_acc <= w_acc_next;
          if (w_j_last) r_rout <= w_acc_next;
          else          r_j    <= r_j + NW'(1);
        end
        EMIT: if (w_r_fire) begin
          r_acc <= '0;
          r_j   <= '0;
          if (!w_k_last) r_k <= r_k + WW'(1);
        end
        default: ;
      endcase
    end
  end

  // Weighting buffer; no reset so it can map onto a RAM
  always_ff @(posedge CLK) begin
    if (w_w_fire) r_buf[r_j[IW-1:0]] <= W_IN;
  end

endmodule

// File: tb/tb_ntm_reading_stage.sv
module tb_ntm_reading_stage;

  localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY, SIZE_ERROR;
  logic [6:0]  SIZE_N_IN = '0;
  logic [6:0]  SIZE_W_IN = '0;
  logic        W_IN_VALID = 1'b0;
  logic        W_IN_READY;
  logic [63:0] W_IN = '0;
  logic        M_IN_VALID = 1'b0;
  logic        M_IN_READY;
  logic [63:0] M_IN = '0;
  logic        R_OUT_VALID;
  logic        R_OUT_READY = 1'b1;
  logic [63:0] R_OUT;
  logic        R_OUT_LAST;

  ntm_reading_stage dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_ERROR(SIZE_ERROR),
    .SIZE_N_IN(SIZE_N_IN), .SIZE_W_IN(SIZE_W_IN),
    .W_IN_VALID(W_IN_VALID), .W_IN_READY(W_IN_READY), .W_IN(W_IN),
    .M_IN_VALID(M_IN_VALID), .M_IN_READY(M_IN_READY), .M_IN(M_IN),
    .R_OUT_VALID(R_OUT_VALID), .R_OUT_READY(R_OUT_READY), .R_OUT(R_OUT),
    .R_OUT_LAST(R_OUT_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          out_idx = 0;
  int          stall_idx = -1;
  int          stall_len = 0;
  int          stall_ctr = 0;
  bit          ready_due = 1'b0;
  logic [63:0] tb_w [64];
  logic [63:0] tb_m [512];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] term(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    return p[95:32];
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Output side: scoreboard pop/compare, optional stall on one word
  always @(negedge CLK) begin
    if (ready_due) begin
      chk_eq("ready_pulse", READY, 1);
      ready_due = 1'b0;
    end
    if (R_OUT_VALID) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_out", R_OUT_VALID, 0);
      end else if (out_idx == stall_idx && stall_ctr < stall_len) begin
        R_OUT_READY = 1'b0;
        stall_ctr++;
        chk_eq("stall_hold", R_OUT, exp_q[0].data);
        chk_eq("stall_last", R_OUT_LAST, exp_q[0].last);
        chk_eq("stall_m_ready", M_IN_READY, 0);
      end else begin
        exp_t e;
        R_OUT_READY = 1'b1;
        e = exp_q.pop_front();
        chk_eq("r_out", R_OUT, e.data);
        chk_eq("r_last", R_OUT_LAST, e.last);
        out_idx++;
        if (e.last) ready_due = 1'b1;
      end
    end
  end

  task automatic do_start(input int n, input int w);
    @(posedge CLK); #1;
    SIZE_N_IN = 7'(n);
    SIZE_W_IN = 7'(w);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Both send tasks start and end at posedge+1
  task automatic send_w(input logic [63:0] d);
    int t = 0;
    W_IN_VALID = 1'b1;
    W_IN = d;
    @(negedge CLK);
    while (!W_IN_READY && t < 100) begin @(negedge CLK); t++; end
    if (t >= 100) chk_eq("w_hs_timeout", W_IN_READY, 1);
    @(posedge CLK); #1;
    W_IN_VALID = 1'b0;
  endtask

  task automatic send_m(input logic [63:0] d);
    int t = 0;
    M_IN_VALID = 1'b1;
    M_IN = d;
    @(negedge CLK);
    while (!M_IN_READY && t < 100) begin @(negedge CLK); t++; end
    if (t >= 100) chk_eq("m_hs_timeout", M_IN_READY, 1);
    @(posedge CLK); #1;
    M_IN_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || ready_due) && t < 2000) begin @(negedge CLK); t++; end
    if (t >= 2000) chk_eq("drain_timeout", 64'(exp_q.size()), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq(tag, {58'd0, READY, SIZE_ERROR, W_IN_READY, M_IN_READY, R_OUT_VALID, R_OUT_LAST}, 0);
    chk_eq({tag, "_rout"}, R_OUT, 0);
  endtask

  task automatic run(input int n, input int w, input int abort_after, input bit start_mid);
    out_idx = 0;
    stall_ctr = 0;
    do_start(n, w);
    @(negedge CLK);
    chk_eq("size_err_clear", SIZE_ERROR, 0);
    @(posedge CLK); #1;
    for (int j = 0; j < n; j++) send_w(tb_w[j]);
    for (int i = 0; i < n * w; i++) begin
      if (start_mid && i == 2) begin
        SIZE_N_IN = 7'd1;
        SIZE_W_IN = 7'd1;
        START = 1'b1;
      end
      send_m(tb_m[i]);
      START = 1'b0;
      if (abort_after == i + 1) begin
        RST = 1'b1;
        #1;
        chk_all_zero("abort_zero");
        exp_q.delete();
        ready_due = 1'b0;
        R_OUT_READY = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        return;
      end
    end
    wait_drain();
  endtask

  task automatic load_t1();
    tb_w[0] = ONE;
    tb_w[1] = ONE >> 1;
    tb_m[0] = 2 * ONE; tb_m[1] = 2 * ONE;
    tb_m[2] = 4 * ONE; tb_m[3] = 2 * ONE;
    tb_m[4] = 6 * ONE; tb_m[5] = 2 * ONE;
  endtask

  task automatic push_t1();
    push_exp(3 * ONE, 1'b0);
    push_exp(5 * ONE, 1'b0);
    push_exp(7 * ONE, 1'b1);
  endtask

  task automatic random_run(input int n, input int w);
    logic [63:0] acc;
    logic [31:0] r;
    for (int j = 0; j < n; j++) begin
      r = $urandom;
      tb_w[j] = {{32{r[31]}}, r};
    end
    for (int i = 0; i < n * w; i++) tb_m[i] = {$urandom, $urandom};
    for (int k = 0; k < w; k++) begin
      acc = '0;
      for (int j = 0; j < n; j++) acc = acc + term(tb_w[j], tb_m[k * n + j]);
      push_exp(acc, k == w - 1);
    end
    run(n, w, 0, 1'b0);
  endtask

  initial begin
    int bad_n [3] = '{0, 65, 1};
    int bad_w [3] = '{3, 1, 0};

    #2;
    chk_all_zero("reset_zero");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Rejected sizes: error flag, READY next cycle, nothing consumed
    for (int i = 0; i < 3; i++) begin
      do_start(bad_n[i], bad_w[i]);
      @(negedge CLK);
      chk_eq("rej_ready", READY, 1);
      chk_eq("rej_size_err", SIZE_ERROR, 1);
      chk_eq("rej_w_ready", W_IN_READY, 0);
      @(negedge CLK);
      chk_eq("rej_ready_end", READY, 0);
      chk_eq("rej_idle_w_ready", W_IN_READY, 0);
    end

    // Basic run (also clears SIZE_ERROR)
    load_t1();
    push_t1();
    run(2, 3, 0, 1'b0);

    // Backpressure on r(1)
    stall_idx = 1;
    stall_len = 5;
    push_t1();
    run(2, 3, 0, 1'b0);
    stall_idx = -1;

    // N=1, W=1: -1.0 * 0.5
    tb_w[0] = 64'hFFFF_FFFF_0000_0000;
    tb_m[0] = 64'h0000_0000_8000_0000;
    push_exp(64'hFFFF_FFFF_8000_0000, 1'b1);
    run(1, 1, 0, 1'b0);

    // Reset after 3 M beats, then a fresh run
    load_t1();
    push_t1();
    run(2, 3, 3, 1'b0);
    push_t1();
    run(2, 3, 0, 1'b0);

    // START during STREAM_M is ignored
    push_t1();
    run(2, 3, 0, 1'b1);

    // Wrapping random data, including maximum N
    random_run(5, 4);
    random_run(64, 2);
    random_run(3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
